// File: rtl/spart_pkg.sv
// Shared SPART constants: frame geometry, bit positions and the receive
// buffer occupancy encoding.
package spart_pkg;

   localparam int SPART_FRAME_W = 10;
   localparam int SPART_DATA_W  = 8;

   localparam int START_BIT = 0;
   localparam int STOP_BIT  = 9;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } rxbuf_state_t;

endpackage

// File: rtl/spart_fifo_mem.sv
// DEPTH x DW register array for the SPART receive FIFO: synchronous write,
// asynchronous read, asynchronous active-low clear of every entry.
module spart_fifo_mem #(
   parameter int DEPTH = 8,
   parameter int DW    = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/spart_rx_buf.sv
// SPART receive buffer: start-bit check, FWFT byte FIFO, sticky overrun and
// framing flags. Define SPART_RX_DROP_CNT_EN to add the drop_cnt output.
//
// state   | meaning
// EMPTY   | no bytes stored, rx_valid low
// PARTIAL | 1..DEPTH-1 bytes stored
// FULL    | DEPTH bytes stored, a push without a pop is dropped
import spart_pkg::*;

module spart_rx_buf #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rda,
   input  logic [SPART_FRAME_W-1:0]   rx_shift_reg,
   input  logic                       rd_en,
   input  logic                       clr_err,
   output logic [SPART_DATA_W-1:0]    rd_data,
   output logic                       rx_valid,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overrun,
   output logic                       frame_err
`ifdef SPART_RX_DROP_CNT_EN
   ,output logic [7:0]                drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   rxbuf_state_t state_q, state_d;

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count_q;
   logic          frame_ok, frame_bad;
   logic          do_push, do_pop, ovr_evt;
   logic          unused_stop;

   assign unused_stop = rx_shift_reg[STOP_BIT];

   assign frame_ok  = rda & ~rx_shift_reg[START_BIT];
   assign frame_bad = rda &  rx_shift_reg[START_BIT];
   assign do_pop    = rd_en & (state_q != EMPTY);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push   = frame_ok & ((state_q != FULL) | do_pop);
   assign ovr_evt   = frame_ok & (state_q == FULL) & ~do_pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (do_push && !do_pop) begin
         state_d = (count_q == CW'(DEPTH - 1)) ? FULL : PARTIAL;
      end else if (do_pop && !do_push) begin
         state_d = (count_q == CW'(1)) ? EMPTY : PARTIAL;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count_q <= count_q + CW'(1);
         else if (do_pop && !do_push) count_q <= count_q - CW'(1);
      end
   end

   // Set wins over clr_err so an error in the clearing cycle is not lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overrun   <= ovr_evt   | (overrun   & ~clr_err);
         frame_err <= frame_bad | (frame_err & ~clr_err);
      end
   end

`ifdef SPART_RX_DROP_CNT_EN
   logic drop_evt;

   assign drop_evt = ovr_evt | frame_bad;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt <= 8'h00;
      end else if (clr_err) begin
         drop_cnt <= {7'd0, drop_evt};
      end else if (drop_evt && drop_cnt != 8'hFF) begin
         drop_cnt <= drop_cnt + 8'h01;
      end
   end
`endif

   spart_fifo_mem #(
      .DEPTH (DEPTH),
      .DW    (SPART_DATA_W),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (do_push),
      .waddr (wr_ptr),
      .wdata (rx_shift_reg[STOP_BIT-1:START_BIT+1]),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   assign rx_valid = (state_q != EMPTY);
   assign full     = (state_q == FULL);
   assign count    = count_q;

endmodule

// File: tb/tb_spart_rx_buf.sv
// Directed bench for spart_rx_buf (DEPTH=8): vector table plus hand-written
// reset and drop-counter sequences.
module tb_spart_rx_buf;

   logic       clk = 1'b0;
   logic       rst;
   logic       rda;
   logic [9:0] rx_shift_reg;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] rd_data;
   logic       rx_valid;
   logic       full;
   logic [3:0] count;
   logic       overrun;
   logic       frame_err;
`ifdef SPART_RX_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   spart_rx_buf #(.DEPTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .rda          (rda),
      .rx_shift_reg (rx_shift_reg),
      .rd_en        (rd_en),
      .clr_err      (clr_err),
      .rd_data      (rd_data),
      .rx_valid     (rx_valid),
      .full         (full),
      .count        (count),
      .overrun      (overrun),
      .frame_err    (frame_err)
`ifdef SPART_RX_DROP_CNT_EN
      ,.drop_cnt    (drop_cnt)
`endif
   );

   typedef struct {
      logic       rda;
      logic [9:0] frm;
      logic       rd_en;
      logic       clr;
      logic [7:0] e_rd;
      logic       e_v;
      logic [3:0] e_cnt;
      logic       e_full;
      logic       e_ov;
      logic       e_fe;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [9:0] frm_of(input logic [7:0] d);
      return {1'b1, d, 1'b0};
   endfunction

   task automatic add(input logic a_rda, input logic [9:0] a_frm, input logic a_rd,
                      input logic a_clr, input logic [7:0] e_rd, input logic e_v,
                      input logic [3:0] e_cnt, input logic e_full, input logic e_ov,
                      input logic e_fe);
      vec_t v;
      v.rda = a_rda; v.frm = a_frm; v.rd_en = a_rd; v.clr = a_clr;
      v.e_rd = e_rd; v.e_v = e_v; v.e_cnt = e_cnt; v.e_full = e_full;
      v.e_ov = e_ov; v.e_fe = e_fe;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic a_rda, input logic [9:0] a_frm, input logic a_rd,
                        input logic a_clr);
      rda = a_rda; rx_shift_reg = a_frm; rd_en = a_rd; clr_err = a_clr;
      @(posedge clk);
      #1;
      rda = 1'b0; rx_shift_reg = '0; rd_en = 1'b0; clr_err = 1'b0;
   endtask

   initial begin
      rst = 1'b0; rda = 1'b0; rx_shift_reg = '0; rd_en = 1'b0; clr_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rd_data", rd_data, 8'h00);
      chk("reset_rx_valid", rx_valid, 1'b0);
      chk("reset_count", count, 4'd0);
      chk("reset_full", full, 1'b0);
      chk("reset_overrun", overrun, 1'b0);
      chk("reset_frame_err", frame_err, 1'b0);
      rst = 1'b1;

      // three frames with idle gaps, then three pops
      add(1, frm_of(8'h55), 0, 0, 8'h55, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) add(0, '0, 0, 0, 8'h55, 1, 1, 0, 0, 0);
      add(1, frm_of(8'hA3), 0, 0, 8'h55, 1, 2, 0, 0, 0);
      for (int i = 0; i < 4; i++) add(0, '0, 0, 0, 8'h55, 1, 2, 0, 0, 0);
      add(1, frm_of(8'hFF), 0, 0, 8'h55, 1, 3, 0, 0, 0);
      add(0, '0, 1, 0, 8'hA3, 1, 2, 0, 0, 0);
      add(0, '0, 1, 0, 8'hFF, 1, 1, 0, 0, 0);
      add(0, '0, 1, 0, 8'h00, 0, 0, 0, 0, 0);

      // fill, overrun on 0x08, drain, clear
      for (int i = 0; i < 8; i++)
         add(1, frm_of(8'(i)), 0, 0, 8'h00, 1, 4'(i + 1), (i == 7), 0, 0);
      add(1, frm_of(8'h08), 0, 0, 8'h00, 1, 8, 1, 1, 0);
      for (int i = 0; i < 8; i++)
         add(0, '0, 1, 0, 8'(i + 1), (i < 7), 4'(7 - i), 0, 1, 0);
      add(0, '0, 0, 1, 8'h00, 0, 0, 0, 0, 0);

      // full with simultaneous push and pop
      for (int i = 0; i < 8; i++)
         add(1, frm_of(8'(i)), 0, 0, 8'h00, 1, 4'(i + 1), (i == 7), 0, 0);
      add(1, frm_of(8'h99), 1, 0, 8'h01, 1, 8, 1, 0, 0);
      for (int i = 0; i < 8; i++)
         add(0, '0, 1, 0, (i < 6) ? 8'(i + 2) : 8'h99, (i < 7), 4'(7 - i), 0, 0, 0);

      // framing error, pop on empty, set-wins over clear
      add(1, 10'h3FF, 0, 0, 8'h00, 0, 0, 0, 0, 1);
      add(0, '0, 1, 0, 8'h00, 0, 0, 0, 0, 1);
      add(1, frm_of(8'h42), 0, 0, 8'h42, 1, 1, 0, 0, 1);
      add(1, 10'h3FF, 0, 1, 8'h42, 1, 1, 0, 0, 1);
      add(0, '0, 0, 1, 8'h42, 1, 1, 0, 0, 0);
      add(0, '0, 1, 0, 8'h00, 0, 0, 0, 0, 0);

      for (int k = 0; k < vecs.size(); k++) begin
         cycle(vecs[k].rda, vecs[k].frm, vecs[k].rd_en, vecs[k].clr);
         if (vecs[k].e_v) chk($sformatf("v%0d_rd_data", k), rd_data, vecs[k].e_rd);
         chk($sformatf("v%0d_rx_valid", k), rx_valid, vecs[k].e_v);
         chk($sformatf("v%0d_count", k), count, vecs[k].e_cnt);
         chk($sformatf("v%0d_full", k), full, vecs[k].e_full);
         chk($sformatf("v%0d_overrun", k), overrun, vecs[k].e_ov);
         chk($sformatf("v%0d_frame_err", k), frame_err, vecs[k].e_fe);
      end

      // asynchronous reset with five bytes stored
      for (int i = 0; i < 5; i++) cycle(1, frm_of(8'hE0 + 8'(i)), 0, 0);
      chk("pre_rst_count", count, 4'd5);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_count", count, 4'd0);
      chk("async_rst_rx_valid", rx_valid, 1'b0);
      chk("async_rst_rd_data", rd_data, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cycle(1, frm_of(8'h3C), 0, 0);
      chk("post_rst_rd_data", rd_data, 8'h3C);
      chk("post_rst_count", count, 4'd1);

`ifdef SPART_RX_DROP_CNT_EN
      for (int i = 0; i < 7; i++) cycle(1, frm_of(8'(i)), 0, 0);
      chk("drop_fill_full", full, 1'b1);
      chk("drop_cnt_zero", drop_cnt, 8'h00);
      for (int i = 0; i < 300; i++) cycle(1, frm_of(8'h77), 0, 0);
      chk("drop_cnt_sat", drop_cnt, 8'hFF);
      chk("drop_overrun", overrun, 1'b1);
      cycle(0, '0, 0, 1);
      chk("drop_cnt_clr", drop_cnt, 8'h00);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spart_rx_buf.md
# spart_rx_buf

Receive buffer that sits directly downstream of the SPART receiver. It captures each completed 10-bit serial frame on the receiver's `rda` pulse, checks the start bit, and pushes the 8 data bits into a DEPTH-entry first-word-fall-through FIFO. The control/bus logic pops bytes from it. Overrun and framing conditions are reported as sticky error flags.

## Interface
- `DEPTH`, default 8: FIFO entries; power of 2, legal range 2..64.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `rda` in 1: one-cycle pulse from the receiver; `rx_shift_reg` is valid in that cycle.
- `rx_shift_reg` in 10: frame; [0] start bit, [8:1] data LSB-first, [9] stop bit.
- `rd_en` in 1: pop request from the bus side.
- `clr_err` in 1: clears the sticky error flags.
- `rd_data` out 8: head-of-FIFO byte; valid while `rx_valid`=1.
- `rx_valid` out 1: FIFO non-empty.
- `full` out 1: count == DEPTH.
- `count` out $clog2(DEPTH)+1: number of occupied entries.
- `overrun` out 1: sticky; a frame was dropped because the FIFO was full.
- `frame_err` out 1: sticky; a frame was dropped because its start bit was 1.

## Operation
- Push condition: `rda`=1 and `rx_shift_reg[0]`=0.
  - Store `rx_shift_reg[8:1]` at `wr_ptr`; advance `wr_ptr`.
- Framing check: `rda`=1 with `rx_shift_reg[0]`=1.
  - Frame is dropped; `frame_err` set; no push; `overrun` unaffected.
- Full: push while full with no simultaneous pop.
  - Frame is dropped; `overrun` set; stored contents unchanged.
- Pop condition: `rd_en`=1 and `rx_valid`=1; advance `rd_ptr`.
  - `rd_en` while empty is ignored; no pointer or count change.
- Simultaneous push and pop, including when full: both are performed and `count` is unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is a separate up/down counter that never exceeds DEPTH or goes below 0.
- `rd_data` = mem[`rd_ptr`], combinational from the storage array (FWFT).
- Error flags:
  - Set in the same cycle their condition occurs; stay set until `clr_err`.
  - If `clr_err` and a set condition occur in the same cycle, set wins.
- Occupancy state, decoded from `count`:
  - EMPTY: count = 0.
  - PARTIAL: count between 1 and DEPTH-1.
  - FULL: count = DEPTH.
  - Transitions happen only on push XOR pop.

## Timing
- Reset values:
  - `rd_ptr`, `wr_ptr`, `count` = 0.
  - `rx_valid`=0, `full`=0, `overrun`=0, `frame_err`=0.
  - `rd_data` = 8'h00; storage is cleared on reset.
- Reset asserted mid-operation discards all stored bytes immediately (asynchronously).
- Push latency:
  - `rda` sampled at edge N.
  - `rx_valid`, `count`, `full` and `rd_data` (if the FIFO was empty) are updated after edge N, i.e. visible in cycle N+1.
- Pop:
  - `rd_data` is valid in the cycle `rd_en` is asserted.
  - The next byte appears after that edge.
- Back-to-back pushes every cycle are accepted; the input side has no backpressure.

## Configuration
- `SPART_RX_DROP_CNT_EN` defined:
  - Adds output `drop_cnt` (out 8): saturating count of all dropped frames (overrun plus framing).
  - Reset value 0; cleared by `clr_err`; holds at 8'hFF.
- Undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `spart_pkg`:
  - `SPART_FRAME_W`=10, `SPART_DATA_W`=8.
  - Frame bit-position constants `START_BIT`=0, `STOP_BIT`=9.
  - Occupancy enum `rxbuf_state_t` {EMPTY, PARTIAL, FULL}.
- One sub-module: `spart_fifo_mem`, the DEPTH x 8 register array.
  - Synchronous write; asynchronous read; async active-low clear.

## Test plan
- Reset, then 3 frames 10'b1_0101_0101_0 (0x55), 0xA3, 0xFF, each `rda` 1 cycle with 4 idle cycles between:
  - Pop order is 0x55, 0xA3, 0xFF.
  - `count` goes 1,2,3 then back to 0; `rx_valid` drops after the third pop.
- Push 8 bytes 0x00..0x07 (DEPTH=8), then push 0x08:
  - `full`=1, `overrun`=1, and 0x08 is discarded.
  - Pops return 0x00..0x07; `clr_err` clears `overrun`.
- FIFO full plus simultaneous push 0x99 and pop:
  - Popped byte is 0x00; `count` stays 8; `overrun`=0; 0x99 is read last.
- `rda` with `rx_shift_reg`=10'h3FF (start bit 1):
  - `frame_err`=1, `count` unchanged.
  - `rd_en` on the empty FIFO leaves pointers unchanged.
- Reset asserted while 5 bytes are stored:
  - `count`=0 and `rx_valid`=0 immediately.
  - Next push of 0x3C reads back 0x3C.
- With `SPART_RX_DROP_CNT_EN` defined: 300 frames dropped while full gives `drop_cnt`=8'hFF; `clr_err` returns it to 0.
